// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin arbiter in front of a single APB master.
//
// A command from one of two requesters is granted in IDLE, driven out as an
// APB SETUP/ACCESS transfer, and completed with a one-cycle resp_valid pulse
// back to the requester that owned the transfer.
//
// Parameters:
//   addr_width - APB address width
//   data_width - APB data width
//   TIMEOUT    - max ACCESS wait cycles, 1..255 (used only with APB_ARB_TIMEOUT_EN)
//
// Ports:
//   pclk, preset_n           clock, asynchronous active-low reset
//   req_valid/req_write[1:0] per-requester command pending / direction
//   req_addr, req_wdata      requester i uses slice i
//   req_ready[1:0]           combinational accept strobe (IDLE only)
//   resp_valid[1:0]          one-cycle completion pulse per requester
//   resp_rdata, resp_err     completion data / timeout flag, valid with resp_valid
//   psel, penable, pwrite,
//   paddr, pwdata            APB master outputs (registered)
//   prdata, pready           APB slave returns
//
// Build option:
//   APB_ARB_TIMEOUT_EN - when defined, an ACCESS phase that sees pready low for
//   TIMEOUT consecutive cycles is abandoned and completed with resp_err=1.
//   When undefined, ACCESS waits indefinitely and resp_err is tied to 0.
module apb_arbiter #(
  parameter int addr_width = 5,
  parameter int data_width = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*addr_width-1:0] req_addr,
  input  logic [2*data_width-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              resp_valid,
  output logic [data_width-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [addr_width-1:0]   paddr,
  output logic [data_width-1:0]   pwdata,
  input  logic [data_width-1:0]   prdata,
  input  logic                    pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   prio;      // requester that wins when both are valid
  logic   owner;     // requester that owns the in-flight transfer
  logic   gnt_vld;
  logic   gnt_id;
  logic   done;

  logic [addr_width-1:0] addr_arr  [2];
  logic [data_width-1:0] wdata_arr [2];

  for (genvar i = 0; i < 2; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*addr_width +: addr_width];
    assign wdata_arr[i] = req_wdata[i*data_width +: data_width];
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic       tmo;
  logic [7:0] tmo_cnt;   // ACCESS cycles elapsed; 0 in the first ACCESS cycle

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)
      tmo_cnt <= '0;
    else if (state == ACCESS)
      tmo_cnt <= tmo_cnt + 8'd1;
    else
      tmo_cnt <= '0;
  end
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt_id    = prio;
    done      = 1'b0;
    req_ready = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      IDLE: begin
        // req_ready is gated by reset so it drops immediately with preset_n.
        if (preset_n && (req_valid != 2'b00)) begin
          gnt_vld           = 1'b1;
          gnt_id            = (req_valid == 2'b11) ? prio : req_valid[1];
          req_ready[gnt_id] = 1'b1;
          state_nxt         = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: APB strobes follow the next state so they line up
  // with the state register; command fields are captured once at grant.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prio       <= 1'b0;
      owner      <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      psel       <= (state_nxt != IDLE);
      penable    <= (state_nxt == ACCESS);
      resp_valid <= 2'b00;
      if (gnt_vld) begin
        owner  <= gnt_id;
        prio   <= ~gnt_id;
        pwrite <= req_write[gnt_id];
        paddr  <= addr_arr[gnt_id];
        pwdata <= wdata_arr[gnt_id];
      end
      if (done) begin
        resp_valid[owner] <= 1'b1;
        resp_rdata        <= pwrite ? '0 : prdata;
`ifdef APB_ARB_TIMEOUT_EN
        resp_err          <= 1'b0;
`endif
      end
`ifdef APB_ARB_TIMEOUT_EN
      if (tmo) begin
        resp_valid[owner] <= 1'b1;
        resp_rdata        <= '0;
        resp_err          <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: self-checking bench for apb_arbiter (default parameters).
// Table-driven single transfers plus hand-written sequences for round-robin
// back-to-back traffic, reset during ACCESS and the ACCESS timeout/hang case.
// Completions are checked against a scoreboard queue filled at grant time.
module tb_apb_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  apb_arbiter #(.addr_width(AW), .data_width(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prd;
    int            dly;
  } vec_t;

  typedef struct {
    logic [1:0]    rv;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Completion monitor: every resp_valid pulse must match the oldest grant.
  always @(negedge pclk) begin
    chk("onehot", {30'd0, req_ready == 2'b11, resp_valid == 2'b11}, 64'd0);
    if (resp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=%b, expected none", resp_valid);
      end else begin
        mon_e = sb.pop_front();
        chk("resp", {45'd0, resp_valid, resp_rdata, resp_err},
            {45'd0, mon_e.rv, mon_e.rdata, mon_e.err});
      end
    end
  end

  task automatic wait_ready(input int id);
    int n = 0;
    while (1) begin
      @(negedge pclk);
      if (req_ready[id]) break;
      n++;
      if (n > 50) begin
        checks++;
        fails++;
        $display("FAIL grant_wait: got no req_ready[%0d], expected within 50 cycles", id);
        break;
      end
    end
  endtask

  task automatic do_xfer(input vec_t v);
    @(posedge pclk); #1;
    req_write[v.id]            = v.wr;
    req_addr[v.id*AW +: AW]    = v.addr;
    req_wdata[v.id*DW +: DW]   = v.wdata;
    req_valid[v.id]            = 1'b1;
    wait_ready(v.id);
    chk("grant", {62'd0, req_ready}, 64'(1 << v.id));
    sb.push_back('{rv: 2'(1 << v.id), rdata: (v.wr ? 16'h0 : v.prd), err: 1'b0});
    @(posedge pclk); #1;
    req_valid = 2'b00;
    prdata    = v.prd;
    @(negedge pclk);
    chk("setup", {psel, penable, pwrite, paddr, pwdata},
        {1'b1, 1'b0, v.wr, v.addr, v.wdata});
    @(posedge pclk); #1;
    pready = (v.dly == 0);
    for (int k = 0; k <= v.dly; k++) begin
      @(negedge pclk);
      chk("access", {psel, penable, pwrite, paddr, pwdata},
          {1'b1, 1'b1, v.wr, v.addr, v.wdata});
      @(posedge pclk); #1;
      pready = (k + 1 == v.dly);
    end
    @(negedge pclk);
    chk("complete", {60'd0, psel, penable, resp_valid}, {60'd0, 2'b00, 2'(1 << v.id)});
  endtask

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_rdy;

    vecs[0] = '{id: 0, wr: 1'b1, addr: 5'h03, wdata: 16'hA5A5, prd: 16'hDEAD, dly: 0};
    vecs[1] = '{id: 1, wr: 1'b0, addr: 5'h03, wdata: 16'h0000, prd: 16'hA5A5, dly: 3};
    vecs[2] = '{id: 0, wr: 1'b0, addr: 5'h1F, wdata: 16'h1357, prd: 16'h5A5A, dly: 1};
    vecs[3] = '{id: 1, wr: 1'b1, addr: 5'h00, wdata: 16'hFFFF, prd: 16'hBEEF, dly: 2};

    // Reset state, with both requesters already asserting.
    preset_n  = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = 16'h1234;
    pready    = 1'b1;
    #22;
    chk("reset_state", {psel, penable, pwrite, paddr, pwdata, req_ready, resp_valid, resp_rdata, resp_err},
        '0);

    // Back-to-back round-robin with pready tied high.
    @(posedge pclk); #1;
    preset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      exp_rdy = (c % 3 == 0) ? 2'(1 << ((c / 3) % 2)) : 2'b00;
      chk("rr_grant", {62'd0, req_ready}, {62'd0, exp_rdy});
      if (exp_rdy != 2'b00) sb.push_back('{rv: exp_rdy, rdata: 16'h1234, err: 1'b0});
      @(posedge pclk); #1;
    end
    req_valid = 2'b00;
    pready    = 1'b0;
    @(negedge pclk);
    chk("rr_last_resp", {62'd0, resp_valid}, 64'd2);

    // Single transfers from the table.
    foreach (vecs[i]) do_xfer(vecs[i]);

    // Reset asserted in the middle of a req0 read ACCESS.
    @(posedge pclk); #1;
    req_write[0]   = 1'b0;
    req_addr[4:0]  = 5'h0A;
    req_valid[0]   = 1'b1;
    prdata         = 16'h1111;
    wait_ready(0);
    chk("rst_grant", {62'd0, req_ready}, 64'd1);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("rst_in_access", {62'd0, psel, penable}, 64'd3);
    #2;
    preset_n  = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst_async", {psel, penable, pwrite, paddr, pwdata, req_ready, resp_valid, resp_rdata, resp_err},
        '0);
    @(posedge pclk); #1;
    preset_n = 1'b1;
    prdata   = 16'h2222;
    @(negedge pclk);
    chk("rst_prio", {62'd0, req_ready}, 64'd1);
    sb.push_back('{rv: 2'b01, rdata: 16'h2222, err: 1'b0});
    @(posedge pclk); #1;
    req_valid = 2'b00;
    pready    = 1'b1;
    @(posedge pclk);
    @(posedge pclk); #1;
    pready = 1'b0;
    @(negedge pclk);
    chk("rst_next_resp", {62'd0, resp_valid}, 64'd1);

    // Slave never ready: timeout (macro build) or indefinite wait.
    @(posedge pclk); #1;
    req_write[1]   = 1'b0;
    req_addr[9:5]  = 5'h07;
    req_valid[1]   = 1'b1;
    prdata         = 16'hFFFF;
    wait_ready(1);
    chk("hang_grant", {62'd0, req_ready}, 64'd2);
`ifdef APB_ARB_TIMEOUT_EN
    sb.push_back('{rv: 2'b10, rdata: 16'h0000, err: 1'b1});
`else
    sb.push_back('{rv: 2'b10, rdata: 16'hFFFF, err: 1'b0});
`endif
    @(posedge pclk); #1;
    req_valid = 2'b00;
    @(negedge pclk);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge pclk);
      if (psel && penable) n++;
      else break;
`ifndef APB_ARB_TIMEOUT_EN
      if (n == 40) break;
`endif
    end
`ifdef APB_ARB_TIMEOUT_EN
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_resp", {45'd0, psel, penable, resp_valid, resp_err}, {45'd0, 1'b0, 1'b0, 2'b10, 1'b1});
`else
    chk("hang_cycles", 64'(n), 64'd40);
    chk("hang_err", {63'd0, resp_err}, 64'd0);
    @(posedge pclk); #1;
    pready = 1'b1;
    @(posedge pclk); #1;
    pready = 1'b0;
    @(negedge pclk);
    chk("hang_resp", {62'd0, resp_valid}, 64'd2);
`endif

    repeat (3) @(posedge pclk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
